// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: 4-entry FIFO feeding a two-state IDLE/EXEC issue FSM.
// Optional ISSUE_STATS_EN macro adds retired_count and stall_cycles counters.
module instr_issue_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        halt,
  output logic [15:0] iin,
  output logic        proc_run,
  output logic        issue_pulse,
  output logic        retire_pulse,
  output logic [2:0]  fifo_count,
  output logic        idle,
  output logic        fsm_state
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0] retired_count,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  cyc;
  logic [15:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic        push;
  logic        pop;
  logic [15:0] head;
  logic [1:0]  head_lat_m1;

  // Handshake: an instruction transfers on every rising edge where in_valid and
  // in_ready are both high; in_ready depends only on occupancy, never on a pop.
  assign in_ready = (fifo_count < 3'd4);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // Moves and output instructions finish in 2 cycles, everything else in 4.
  always_comb begin
    head_lat_m1 = 2'd3;
    if (head[15:13] == 3'b000 || head[15:13] == 3'b001 || head[15:13] == 3'b111)
      head_lat_m1 = 2'd1;
  end

  // A pop happens only when the FSM is free to issue: idle, or on the retire cycle.
  assign pop = (fifo_count != 3'd0) && !halt &&
               ((state == IDLE) || (state == EXEC && cyc == 2'd0));

  assign idle      = (state == IDLE) && (fifo_count == 3'd0);
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cyc          <= 2'd0;
      iin          <= 16'h0000;
      proc_run     <= 1'b0;
      issue_pulse  <= 1'b0;
      retire_pulse <= 1'b0;
    end else begin
      issue_pulse  <= 1'b0;
      retire_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            iin         <= head;
            cyc         <= head_lat_m1;
            state       <= EXEC;
            proc_run    <= 1'b1;
            issue_pulse <= 1'b1;
          end
        end
        EXEC: begin
          if (cyc != 2'd0) begin
            cyc          <= cyc - 2'd1;
            retire_pulse <= (cyc == 2'd1);
          end else if (pop) begin
            // Back-to-back issue straight out of the retire cycle.
            iin         <= head;
            cyc         <= head_lat_m1;
            issue_pulse <= 1'b1;
          end else begin
            state    <= IDLE;
            proc_run <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_count <= 16'h0000;
      stall_cycles  <= 16'h0000;
    end else begin
      if (retire_pulse && retired_count != 16'hFFFF)
        retired_count <= retired_count + 16'd1;
      if ((fifo_count != 3'd0) && (state == IDLE) && halt && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
